// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for the eight-digit seven-segment display.
// A 32-bit value is latched once per frame into a shadow register.
// Its nibbles are then scanned onto digits 0 (rightmost) through 7.
// Leading zeros can be blanked, and each digit has its own decimal point.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   BLANK_LZ  1 blanks leading zero digits, 0 shows all eight
// Ports:
//   clk1     board clock
//   rst      synchronous active-high reset
//   data     value to display, nibble k on digit k
//   dp_mask  per-digit decimal point enables, sampled with data
//   freeze   skips the frame-boundary capture while high
//   AN       digit enables, active-low
//   SEG      {dp, g..a}, active-low
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        freeze,
    output logic [7:0]  AN,
    output logic [7:0]  SEG
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadowData_q, shadowData_d;
    logic [7:0]    shadowDp_q, shadowDp_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick;
    logic [3:0]    nibble;
    logic [31:0]   upperBits;
    logic          blanked;

    // Hex digit to active-low gfedcba pattern.
    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    assign tick   = (presc_q == PRESC_MAX);
    assign nibble = shadowData_q[{idx_q, 2'b00} +: 4];

    // The current digit is a leading zero when it and everything above it are
    // zero. Digit 0 is always shown, so a zero value still displays as "0".
    assign upperBits = shadowData_q >> {idx_q, 2'b00};
    assign blanked   = BLANK_LZ && (idx_q != 3'd0) && (upperBits == 32'd0);

    // Prescaler, digit index and shadow capture.
    // The shadow only moves at the end of digit 7, so a frame never mixes two values.
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        shadowData_d = shadowData_q;
        shadowDp_d   = shadowDp_q;
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
            if ((idx_q == 3'd7) && !freeze) begin
                shadowData_d = data;
                shadowDp_d   = dp_mask;
            end
        end
    end

    // Output pattern for the next cycle.
    // The tick cycle is forced dark, so the old digit's segments never
    // flash on the new anode while the index changes.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (!tick && !blanked) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = {~shadowDp_q[idx_q], segCode(nibble)};
        end
    end

    // State and output registers.
    // Reset restarts the scan at digit 0 with an empty shadow.
    always_ff @(posedge clk1) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            shadowData_q <= 32'd0;
            shadowDp_q   <= 8'd0;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadowData_q <= shadowData_d;
            shadowDp_q   <= shadowDp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with SCAN_DIV=4.
// It drives two instances from the same inputs: one with leading-zero
// blanking and one without.
// A small reference model tracks the prescaler, digit index and shadow value.
// Known points in the scan are also checked against hand-computed constants.
module tb_seg_scan_driver;

    logic        clk1 = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic        freeze = 1'b0;
    logic [7:0]  anA, segA, anB, segB;

    int checkCount = 0;
    int failCount = 0;

    int          mPresc = 0;
    int          mIdx = 0;
    int          mT = 0;
    logic [31:0] mShadow = 32'd0;
    logic [7:0]  mDp = 8'd0;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dutLz (
        .clk1(clk1), .rst(rst), .data(data), .dp_mask(dp_mask),
        .freeze(freeze), .AN(anA), .SEG(segA)
    );

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dutAll (
        .clk1(clk1), .rst(rst), .data(data), .dp_mask(dp_mask),
        .freeze(freeze), .AN(anB), .SEG(segB)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[n];
    endfunction

    // Expected {AN, SEG} for the model state reached after the latest edge.
    function automatic logic [15:0] expOut(input bit lz);
        logic [31:0] upper;
        logic [3:0]  nib;
        logic [7:0]  an;
        if (mPresc == 0) return 16'hFFFF;
        upper = mShadow >> (4 * mIdx);
        if (lz && mIdx != 0 && upper == 32'd0) return 16'hFFFF;
        nib = upper[3:0];
        an  = ~(8'b1 << mIdx);
        return {an, ~mDp[mIdx], segCode(nib)};
    endfunction

    // One clock edge. The model samples the same inputs the DUT sees.
    task automatic step();
        @(posedge clk1);
        mT++;
        if (rst) begin
            mPresc  = 0;
            mIdx    = 0;
            mShadow = 32'd0;
            mDp     = 8'd0;
            mT      = 0;
        end else if (mPresc == 3) begin
            if (mIdx == 7 && !freeze) begin
                mShadow = data;
                mDp     = dp_mask;
            end
            mPresc = 0;
            mIdx   = (mIdx + 1) % 8;
        end else begin
            mPresc++;
        end
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk1);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        data = 32'h12345678; dp_mask = 8'h00; freeze = 1'b0;
        applyReset();
        checkCount++;
        if (anA !== 8'hFF) begin failCount++; $display("[TB] FAIL reset_anA got %h expected ff", anA); end
        checkCount++;
        if (segA !== 8'hFF) begin failCount++; $display("[TB] FAIL reset_segA got %h expected ff", segA); end
        checkCount++;
        if (anB !== 8'hFF) begin failCount++; $display("[TB] FAIL reset_anB got %h expected ff", anB); end
        checkCount++;
        if (segB !== 8'hFF) begin failCount++; $display("[TB] FAIL reset_segB got %h expected ff", segB); end
        step();
        checkCount++;
        if ({anA, segA} !== 16'hFEC0) begin failCount++; $display("[TB] FAIL reset_frame0_digit0 got %h expected fec0", {anA, segA}); end
        for (int c = 0; c < 31; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL reset_scan_lz t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
            checkCount++;
            if ({anB, segB} !== expOut(1'b0)) begin failCount++; $display("[TB] FAIL reset_scan_all t=%0d got %h expected %h", mT, {anB, segB}, expOut(1'b0)); end
        end
        // t=33: frame 1 digit 0 shows nibble 8
        step();
        checkCount++;
        if ({anA, segA} !== 16'hFE80) begin failCount++; $display("[TB] FAIL frame1_digit0 got %h expected fe80", {anA, segA}); end
        for (int c = 0; c < 30; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL frame1_scan t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
        // t=63: last cycle of digit 7, nibble 1
        checkCount++;
        if ({anA, segA} !== 16'h7FF9) begin failCount++; $display("[TB] FAIL frame1_digit7 got %h expected 7ff9", {anA, segA}); end
    endtask

    task automatic test_blanking();
        data = 32'h000000A0; dp_mask = 8'h00; freeze = 1'b0;
        applyReset();
        for (int c = 0; c < 64; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL blank_lz t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
            checkCount++;
            if ({anB, segB} !== expOut(1'b0)) begin failCount++; $display("[TB] FAIL blank_all t=%0d got %h expected %h", mT, {anB, segB}, expOut(1'b0)); end
        end
        repeat (5) step();
        checkCount++;
        if ({anA, segA} !== 16'hFD88) begin failCount++; $display("[TB] FAIL blank_digit1 got %h expected fd88", {anA, segA}); end
        repeat (4) step();
        checkCount++;
        if ({anA, segA} !== 16'hFFFF) begin failCount++; $display("[TB] FAIL blank_digit2_lz got %h expected ffff", {anA, segA}); end
        checkCount++;
        if ({anB, segB} !== 16'hFBC0) begin failCount++; $display("[TB] FAIL blank_digit2_all got %h expected fbc0", {anB, segB}); end
    endtask

    task automatic test_dp();
        data = 32'hFFFFFFFF; dp_mask = 8'h04; freeze = 1'b0;
        applyReset();
        for (int c = 0; c < 64; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL dp_scan t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
        repeat (9) step();
        checkCount++;
        if ({anA, segA} !== 16'hFB0E) begin failCount++; $display("[TB] FAIL dp_digit2 got %h expected fb0e", {anA, segA}); end
        repeat (4) step();
        checkCount++;
        if ({anA, segA} !== 16'hF78E) begin failCount++; $display("[TB] FAIL dp_digit3 got %h expected f78e", {anA, segA}); end
    endtask

    task automatic test_freeze();
        data = 32'h1; dp_mask = 8'h00; freeze = 1'b0;
        applyReset();
        repeat (32) step();
        freeze = 1'b1;
        data   = 32'h2;
        for (int c = 0; c < 33; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL freeze_scan t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
        // t=65: the capture at t=64 was skipped, so the old digit remains
        checkCount++;
        if ({anA, segA} !== 16'hFEF9) begin failCount++; $display("[TB] FAIL freeze_hold got %h expected fef9", {anA, segA}); end
        freeze = 1'b0;
        for (int c = 0; c < 31; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL freeze_release_scan t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
        step();
        checkCount++;
        if ({anA, segA} !== 16'hFEA4) begin failCount++; $display("[TB] FAIL freeze_release got %h expected fea4", {anA, segA}); end
    endtask

    task automatic test_midscan_reset();
        data = 32'h3; dp_mask = 8'h01; freeze = 1'b0;
        applyReset();
        // 54 edges puts frame 1 at digit 5, presc 2
        for (int c = 0; c < 54; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL midrst_scan t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCount++;
        if ({anA, segA} !== 16'hFFFF) begin failCount++; $display("[TB] FAIL midrst_guard got %h expected ffff", {anA, segA}); end
        step();
        // cleared shadow: plain "0" on digit 0, no decimal point
        checkCount++;
        if ({anA, segA} !== 16'hFEC0) begin failCount++; $display("[TB] FAIL midrst_digit0 got %h expected fec0", {anA, segA}); end
        for (int c = 0; c < 8; c++) begin
            step();
            checkCount++;
            if ({anA, segA} !== expOut(1'b1)) begin failCount++; $display("[TB] FAIL midrst_after t=%0d got %h expected %h", mT, {anA, segA}, expOut(1'b1)); end
        end
    endtask

    task automatic test_tearing();
        logic [7:0] firstSeg;
        data = 32'h0; dp_mask = 8'h00; freeze = 1'b0;
        applyReset();
        firstSeg = 8'h00;
        for (int c = 0; c < 96; c++) begin
            step();
            data = ~data;
            checkCount++;
            if ({anB, segB} !== expOut(1'b0)) begin failCount++; $display("[TB] FAIL tear_scan t=%0d got %h expected %h", mT, {anB, segB}, expOut(1'b0)); end
            // every lit digit of a frame must match digit 0 of that frame
            if (mPresc != 0) begin
                if (mIdx == 0) firstSeg = segB;
                else begin
                    checkCount++;
                    if (segB !== firstSeg) begin failCount++; $display("[TB] FAIL tear_uniform t=%0d got %h expected %h", mT, segB, firstSeg); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_dp();
        test_freeze();
        test_midscan_reset();
        test_tearing();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
